// File: rtl/jk_bank_sequencer_if.sv
// Command, bank and status signals between a register-access master and jk_bank_sequencer.
// The master side also drives the bank's q feedback into the sequencer.
interface jk_bank_sequencer_if #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
);
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int FCNT_W = $clog2(DEPTH) + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [IDX_W-1:0]  cmd_idx;
    logic [CNT_W-1:0]  cmd_cnt;
    logic [N-1:0]      j;
    logic [N-1:0]      k;
    logic [N-1:0]      q_fb;
    logic              busy;
    logic              done;
    logic              err;
    logic [FCNT_W-1:0] fifo_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_cnt, q_fb,
        input  cmd_ready, j, k, busy, done, err, fifo_cnt
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_cnt, q_fb,
        output cmd_ready, j, k, busy, done, err, fifo_cnt
    );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Queues hold/reset/set/toggle commands and pulses one J/K pair of a JK bank per command step,
// verifying each pulse through q feedback and flagging mismatches in a sticky err bit.
module jk_bank_sequencer #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    jk_bank_sequencer_if.slave bus
);
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FCNT_W = $clog2(DEPTH) + 1;
    localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(DEPTH);
    localparam logic [IDX_W:0]    IDX_LIMIT = (IDX_W + 1)'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_mem_op  [DEPTH];
    logic [IDX_W-1:0]   r_mem_idx [DEPTH];
    logic [CNT_W-1:0]   r_mem_cnt [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [FCNT_W-1:0]  r_count;

    logic [1:0]         r_op;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_rem;
    logic               r_exp;
    logic [N-1:0]       r_j;
    logic [N-1:0]       r_k;
    logic               r_done;
    logic               r_err;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_head_op;
    logic [IDX_W-1:0]   w_head_idx;
    logic [CNT_W-1:0]   w_head_cnt;
    logic               w_head_noop;
    logic [1:0]         w_drv_op;
    logic [IDX_W-1:0]   w_drv_idx;
    logic [N-1:0]       w_j_nxt;
    logic [N-1:0]       w_k_nxt;
    logic               w_q_sel;
    logic               w_exp_nxt;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = bus.cmd_valid && !w_full;
    assign w_pop      = (r_state == S_LOAD);
    assign w_head_op  = r_mem_op[r_rd_ptr];
    assign w_head_idx = r_mem_idx[r_rd_ptr];
    assign w_head_cnt = r_mem_cnt[r_rd_ptr];
    // Zero repeat count and out-of-range bit index both complete without touching the bank.
    assign w_head_noop = (w_head_cnt == '0) || ({1'b0, w_head_idx} >= IDX_LIMIT);
    assign w_q_sel    = bus.q_fb[r_idx];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr]  <= bus.cmd_op;
            r_mem_idx[r_wr_ptr] <= bus.cmd_idx;
            r_mem_cnt[r_wr_ptr] <= bus.cmd_cnt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (!w_empty) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = w_head_noop ? S_DONE : S_DRIVE;
            S_DRIVE: w_state_nxt = S_CHECK;
            S_CHECK: w_state_nxt = (r_rem == CNT_W'(1)) ? S_DONE : S_DRIVE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // j/k are registered, so the pulse is decoded on entry to DRIVE; from LOAD the
    // working registers are not yet valid and the FIFO head is used instead.
    always_comb begin
        w_j_nxt   = '0;
        w_k_nxt   = '0;
        w_drv_op  = (r_state == S_LOAD) ? w_head_op  : r_op;
        w_drv_idx = (r_state == S_LOAD) ? w_head_idx : r_idx;
        if (w_state_nxt == S_DRIVE) begin
            for (int unsigned b = 0; b < N; b++) begin
                if (w_drv_idx == IDX_W'(b)) begin
                    w_j_nxt[b] = w_drv_op[1];
                    w_k_nxt[b] = w_drv_op[0];
                end
            end
        end
    end

    always_comb begin
        w_exp_nxt = w_q_sel;
        unique case (r_op)
            2'b00: w_exp_nxt = w_q_sel;
            2'b01: w_exp_nxt = 1'b0;
            2'b10: w_exp_nxt = 1'b1;
            2'b11: w_exp_nxt = ~w_q_sel;
            default: w_exp_nxt = w_q_sel;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_op     <= '0;
            r_idx    <= '0;
            r_rem    <= '0;
            r_exp    <= 1'b0;
            r_j      <= '0;
            r_k      <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_done  <= (w_state_nxt == S_DONE);

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (r_state == S_LOAD) begin
                r_op  <= w_head_op;
                r_idx <= w_head_idx;
                r_rem <= w_head_cnt;
            end
            if (r_state == S_DRIVE) r_exp <= w_exp_nxt;
            if (r_state == S_CHECK) begin
                r_rem <= r_rem - 1'b1;
                if (w_q_sel != r_exp) r_err <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.j         = r_j;
    assign bus.k         = r_k;
    assign bus.busy      = (r_state != S_IDLE) || !w_empty;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.fifo_cnt  = r_count;
endmodule
